// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver:
// display mode encoding, blank glyph, converter widths and the hex glyph table.
package seg7_pkg;

    localparam logic [2:0] MODE_HEX  = 3'd0;
    localparam logic [2:0] MODE_CI   = 3'd1;
    localparam logic [2:0] MODE_CR   = 3'd2;
    localparam logic [2:0] MODE_CJ   = 3'd3;
    localparam logic [2:0] MODE_CCLK = 3'd4;

    // All segments off (segments are active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int BIN_W = 11;
    localparam int BCD_W = 16;

    // Nibble to active-low {g,f,e,d,c,b,a} pattern
    function automatic logic [6:0] hex2seg(input logic [3:0] val);
        logic [6:0] pat;
        case (val)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: 11-bit binary to four BCD digits.
// One add-3/shift iteration per cycle; done is a one-cycle pulse 12 cycles
// after start. A start pulse always (re)starts the conversion.
module bin2bcd
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [BIN_W-1:0] bin_reg;
    logic [BCD_W-1:0] bcd_reg;
    logic [3:0]       iter_reg;
    logic [11:0]      adj_low;

    // Add-3 correction for the three low digits; the thousands digit never
    // exceeds 1 before the final shift (max input 2047), so it needs none.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            assign adj_low[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
        end
    endgenerate

    // Conversion FSM: IDLE -> SHIFT (11 iterations) -> DONE -> IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            iter_reg  <= '0;
        end else if (start) begin
            state_reg <= S_SHIFT;
            bin_reg   <= bin;
            bcd_reg   <= '0;
            iter_reg  <= '0;
        end else begin
            case (state_reg)
                S_SHIFT: begin
                    bcd_reg  <= {bcd_reg[14:12], adj_low, bin_reg[BIN_W-1]};
                    bin_reg  <= {bin_reg[BIN_W-2:0], 1'b0};
                    iter_reg <= iter_reg + 4'd1;
                    if (iter_reg == 4'd10) begin
                        state_reg <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign done = (state_reg == S_DONE);
    assign bcd  = bcd_reg;

endmodule

// File: rtl/seg7_scan_display.sv
// 8-digit multiplexed seven-segment driver for the CPU observation outputs.
// Shows the syscall word in hex or one of four statistics counters in decimal,
// chosen by a mode button. Optional feature macro: LEADING_ZERO_BLANK_EN
// (blank zero digits above the most significant non-zero digit).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] hex_in,
    input  logic [10:0] cnt_i,
    input  logic [10:0] cnt_r,
    input  logic [10:0] cnt_j,
    input  logic [10:0] cnt_clk,
    input  logic        mode_btn,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int               CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    logic             btn_meta_reg, btn_sync_reg, btn_prev_reg;
    logic             btn_rise;
    logic [2:0]       mode_reg;
    logic [CNT_W-1:0] scan_cnt_reg;
    logic [2:0]       idx_reg;
    logic             frame_start;
    logic [31:0]      src_word;
    logic [31:0]      snap_reg;
    logic             disp_hex_reg;
    logic [15:0]      bcd_reg;
    logic             conv_done;
    logic [15:0]      conv_bcd;
    logic [3:0]       digit_val;
    logic             digit_blank;
    logic [7:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;

    // Button synchronizer plus edge-detect history flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_reg <= 1'b0;
            btn_sync_reg <= 1'b0;
            btn_prev_reg <= 1'b0;
        end else begin
            btn_meta_reg <= mode_btn;
            btn_sync_reg <= btn_meta_reg;
            btn_prev_reg <= btn_sync_reg;
        end
    end

    assign btn_rise = btn_sync_reg & ~btn_prev_reg;

    // Mode advances once per button press, wrapping after the clock counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg <= MODE_HEX;
        end else if (btn_rise) begin
            mode_reg <= (mode_reg == MODE_CCLK) ? MODE_HEX : mode_reg + 3'd1;
        end
    end

    // Digit slot timer and digit index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_reg <= '0;
            idx_reg      <= '0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg <= '0;
            idx_reg      <= idx_reg + 3'd1;
        end else begin
            scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
    end

    assign frame_start = (idx_reg == 3'd0) && (scan_cnt_reg == '0);

    // Source selected by the current mode, counters zero-extended
    always_comb begin
        src_word = hex_in;
        case (mode_reg)
            MODE_CI:   src_word = {21'd0, cnt_i};
            MODE_CR:   src_word = {21'd0, cnt_r};
            MODE_CJ:   src_word = {21'd0, cnt_j};
            MODE_CCLK: src_word = {21'd0, cnt_clk};
            default:   src_word = hex_in;
        endcase
    end

    // Freeze the source and its radix for a whole frame so digits stay coherent
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_reg     <= '0;
            disp_hex_reg <= 1'b1;
        end else if (frame_start) begin
            snap_reg     <= src_word;
            disp_hex_reg <= (mode_reg == MODE_HEX);
        end
    end

    bin2bcd u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (frame_start),
        .bin   (src_word[10:0]),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Decimal digits update only when a conversion completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd_reg <= '0;
        end else if (conv_done) begin
            bcd_reg <= conv_bcd;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] hex_upper_zero;
    logic [3:0] bcd_upper_zero;

    // Per-position flag: this digit and everything above it are zero
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_hex_lz
            assign hex_upper_zero[gi] = ((snap_reg >> (4 * gi)) == 32'd0);
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd_lz
            assign bcd_upper_zero[gi] = ((bcd_reg >> (4 * gi)) == 16'd0);
        end
    endgenerate
`endif

    // Digit value and blanking for the slot currently being scanned
    always_comb begin
        digit_val   = 4'd0;
        digit_blank = 1'b0;
        if (disp_hex_reg) begin
            digit_val = snap_reg[{idx_reg, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            digit_blank = (idx_reg != 3'd0) && hex_upper_zero[idx_reg];
`endif
        end else begin
            digit_val   = bcd_reg[{idx_reg[1:0], 2'b00} +: 4];
            digit_blank = idx_reg[2];
`ifdef LEADING_ZERO_BLANK_EN
            digit_blank = idx_reg[2] ||
                          ((idx_reg != 3'd0) && bcd_upper_zero[idx_reg[1:0]]);
`endif
        end
    end

    // Registered pin drivers; dp marks the digit whose position equals the mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_reg  <= 8'hFF;
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= ~(8'd1 << idx_reg);
            seg_reg <= digit_blank ? SEG_BLANK : hex2seg(digit_val);
            dp_reg  <= (idx_reg != mode_reg);
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display with SCAN_DIV=16.
module tb_seg7_scan_display;

    localparam int SCAN_DIV = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] hex_in;
    logic [10:0] cnt_i, cnt_r, cnt_j, cnt_clk;
    logic        mode_btn;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .hex_in   (hex_in),
        .cnt_i    (cnt_i),
        .cnt_r    (cnt_r),
        .cnt_j    (cnt_j),
        .cnt_clk  (cnt_clk),
        .mode_btn (mode_btn),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    typedef struct {
        int          mode;
        logic [31:0] hex;
        logic [10:0] cnt;
    } vec_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         model_mode = 0;
    exp_t       sb_q[$];
    vec_t       vecs[8];
    logic [6:0] glyph[16];
    logic [6:0] cap_seg[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference digit pattern computed arithmetically
    function automatic logic [6:0] model_seg(input int m, input logic [31:0] h, input int c, input int k);
        int d;
        int p;
        bit blank;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (m == 0) begin
            d = int'((h >> (4 * k)) & 32'hF);
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (k != 0) && ((h >> (4 * k)) == 32'd0);
`endif
        end else begin
            d = (c / p) % 10;
            blank = (k >= 4);
`ifdef LEADING_ZERO_BLANK_EN
            blank = blank || ((k != 0) && (c < p));
`endif
        end
        return blank ? 7'h7F : glyph[d];
    endfunction

    // Wait until the anodes step from digit 7 to digit 0 (a frame start)
    task automatic wait_frame(output bit ok);
        logic [7:0] prev;
        ok = 1'b0;
        prev = an;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (prev == 8'h7F && an == 8'hFE) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frame_sync: an=%h never stepped 7F->FE within 400 cycles", an);
        end
    endtask

    task automatic press_to(input int target);
        while (model_mode != target) begin
            mode_btn = 1'b1;
            tick(4);
            mode_btn = 1'b0;
            tick(3);
            model_mode = (model_mode == 4) ? 0 : model_mode + 1;
            $display("press: mode now %0d", model_mode);
        end
    endtask

    // Sample the middle of each digit slot and compare against the scoreboard
    task automatic capture(input string tag);
        exp_t e;
        tick(8);
        for (int k = 0; k < 8; k++) begin
            e = sb_q.pop_front();
            check($sformatf("%s digit%0d {an,seg,dp}", tag, k), {16'd0, an, seg, dp}, {16'd0, e.an, e.seg, e.dp});
            cap_seg[k] = seg;
            if (k < 7) tick(16);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        bit   ok;
        exp_t e;
        hex_in  = (v.mode == 0) ? v.hex : 32'h89AB_CDEF;
        cnt_i   = (v.mode == 1) ? v.cnt : v.cnt ^ 11'h2A5;
        cnt_r   = (v.mode == 2) ? v.cnt : v.cnt ^ 11'h15A;
        cnt_j   = (v.mode == 3) ? v.cnt : v.cnt ^ 11'h333;
        cnt_clk = (v.mode == 4) ? v.cnt : v.cnt ^ 11'h4CC;
        press_to(v.mode);
        for (int k = 0; k < 8; k++) begin
            e.an  = ~(8'd1 << k);
            e.seg = model_seg(v.mode, hex_in, int'(v.cnt), k);
            e.dp  = (k == v.mode) ? 1'b0 : 1'b1;
            sb_q.push_back(e);
        end
        wait_frame(ok);
        if (ok) wait_frame(ok);
        if (ok) capture(tag);
        else sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vec_t rv;

        glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
        glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
        glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;

        vecs[0] = '{0, 32'h00A0_0F18, 11'd0};
        vecs[1] = '{1, 32'h0,         11'd123};
        vecs[2] = '{2, 32'h0,         11'd5};
        vecs[3] = '{3, 32'h0,         11'd1000};
        vecs[4] = '{4, 32'h0,         11'd2047};
        vecs[5] = '{4, 32'h0,         11'd0};
        vecs[6] = '{0, 32'hDEAD_BEEF, 11'd0};
        vecs[7] = '{0, 32'h0000_0000, 11'd0};

        reset = 1'b0; mode_btn = 1'b0; hex_in = '0;
        cnt_i = '0; cnt_r = '0; cnt_j = '0; cnt_clk = '0;
        tick(3);
        check("reset {an,seg,dp}", {16'd0, an, seg, dp}, {16'd0, 8'hFF, 7'h7F, 1'b1});

        reset = 1'b1;
        tick(1);
        check("first edge an", {24'd0, an}, 32'h0000_00FE);
        tick(16);
        check("after 16 cycles an", {24'd0, an}, 32'h0000_00FD);
        tick(112);
        check("after 128 cycles an", {24'd0, an}, 32'h0000_00FE);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) begin
                check("hex d0 '8'", {25'd0, cap_seg[0]}, {25'd0, 7'b0000000});
                check("hex d1 '1'", {25'd0, cap_seg[1]}, {25'd0, 7'b1111001});
                check("hex d2 'F'", {25'd0, cap_seg[2]}, {25'd0, 7'b0001110});
                check("hex d5 'A'", {25'd0, cap_seg[5]}, {25'd0, 7'b0001000});
`ifdef LEADING_ZERO_BLANK_EN
                check("hex d6 blank", {25'd0, cap_seg[6]}, {25'd0, 7'h7F});
                check("hex d7 blank", {25'd0, cap_seg[7]}, {25'd0, 7'h7F});
`else
                check("hex d6 '0'", {25'd0, cap_seg[6]}, {25'd0, 7'b1000000});
                check("hex d7 '0'", {25'd0, cap_seg[7]}, {25'd0, 7'b1000000});
`endif
            end
            if (i == 4) begin
                check("dec d3 '2'", {25'd0, cap_seg[3]}, {25'd0, 7'b0100100});
                check("dec d2 '0'", {25'd0, cap_seg[2]}, {25'd0, 7'b1000000});
                check("dec d1 '4'", {25'd0, cap_seg[1]}, {25'd0, 7'b0011001});
                check("dec d0 '7'", {25'd0, cap_seg[0]}, {25'd0, 7'b1111000});
            end
            if (i == 5) begin
                check("zero d0 '0'", {25'd0, cap_seg[0]}, {25'd0, 7'b1000000});
`ifdef LEADING_ZERO_BLANK_EN
                check("zero d1 blank", {25'd0, cap_seg[1]}, {25'd0, 7'h7F});
`else
                check("zero d1 '0'", {25'd0, cap_seg[1]}, {25'd0, 7'b1000000});
`endif
            end
        end

        // Reset a few cycles into a conversion, then convert again
        rv = '{4, 32'h0, 11'd1234};
        cnt_clk = rv.cnt;
        press_to(4);
        wait_frame(ok);
        tick(4);
        reset = 1'b0;
        #1;
        check("mid-conversion reset {an,seg,dp}", {16'd0, an, seg, dp}, {16'd0, 8'hFF, 7'h7F, 1'b1});
        model_mode = 0;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("post-reset first an", {24'd0, an}, 32'h0000_00FE);
        run_vec("after_reset", rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Multiplexed 8-digit seven-segment driver that consumes the CPU's observable outputs: the 32-bit syscall decoder word and the four 11-bit statistics counters. A mode button cycles between showing the syscall word in hex and each counter in decimal. Decimal values are produced by a sequential double-dabble sub-module. The block sits at board top level between `single_cycle_cpu` and the display pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot; legal minimum 16.
- `clk`  in  1: system clock, same as the CPU.
- `reset`  in  1: asynchronous, active-low reset.
- `hex_in`  in  32: syscall decoder word.
- `cnt_i`, `cnt_r`, `cnt_j`, `cnt_clk`  in  11 each: statistics counters.
- `mode_btn`  in  1: asynchronous push button, active-high.
- `an`  out  8: digit enables, active-low; `an[0]` is the rightmost digit.
- `seg`  out  7: `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1: decimal point, active-low.

## Operation
- **Mode register** `mode`, 3 bits:
  - 0 = hex_in (hex)
  - 1 = cnt_i
  - 2 = cnt_r
  - 3 = cnt_j
  - 4 = cnt_clk
  - Modes 1–4 are shown in decimal.
- **Mode button path:**
  - `mode_btn` passes through a 2-flop synchronizer, then a rising-edge detector.
  - Each detected edge advances `mode` by one; 4 wraps to 0.
  - No debounce; bounce filtering is the board's job.
- **Scan state:**
  - `scan_cnt` counts 0..SCAN_DIV-1. At its wrap, `idx` (3 bits) increments 0..7 and wraps.
  - Frame start = `idx==0 && scan_cnt==0`.
- **Frame start actions:**
  - `snap` (32 bits) loads the source selected by `mode`. Counters are zero-extended.
  - The `bin2bcd` start pulse fires on the same cycle.
- **Digit source:**
  - Mode 0: nibble `snap[4*idx+3:4*idx]`, glyphs 0-9, A-F.
  - Modes 1–4: BCD digit `idx` of register `bcd`. Digits 4..7 are always blank.
- **`bcd` register:**
  - Loads when `bin2bcd` asserts done. Until then the previous frame's value is shown.
  - Because of this, count modes lag by one frame.
- **Decimal point:** `dp` is low only while `idx` equals the digit position `mode`, as a mode indicator. In mode 0, digit 0's dp is lit.
- **Blank digit:** `seg = 7'h7F`; the anode is still driven.
- **Glyph codes:**
  - 0 = 7'b1000000
  - 1 = 7'b1111001
  - 8 = 7'b0000000
  - A = 7'b0001000
  - F = 7'b0001110

## Timing
- **Reset values:** `an=8'hFF`, `seg=7'h7F`, `dp=1`, `mode=0`, `idx=0`, `scan_cnt=0`, `snap=0`, `bcd=0`, synchronizer flops 0.
- **Outputs are registered.** The first edge after reset release is frame start: `snap` loads and `an=8'hFE` shows digit 0 of the old `snap`. The new `snap` is visible from the next edge.
- Exactly one `an` bit is low at any time outside reset.
- **`bin2bcd` timing:** 11 shift/add-3 iterations. Done fires 12 cycles after start, which is well inside one slot since SCAN_DIV ≥ 16.
- **Mode change mid-frame:** takes effect at the next frame start, except `dp`, which updates on the next edge.
- **Simultaneous mode edge and frame start:** `snap` samples the old mode.
- **Reset mid-conversion:** aborts `bin2bcd` and clears its state.
- **`bin2bcd` start while busy:** cannot occur by construction. If it does, it restarts.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - Zero digits above the most significant non-zero digit are blanked, in all modes.
  - Digit 0 is never blanked.
  - Blanking is evaluated on `snap` (mode 0) or `bcd` (modes 1–4).
- Undefined: all eight hex digits are shown, and decimal digits 0..3 are shown with leading zeros.

## Structure
- Package `seg7_pkg` holds:
  - the mode encoding constants (`MODE_HEX`, `MODE_CI`, `MODE_CR`, `MODE_CJ`, `MODE_CCLK`);
  - the blank code `SEG_BLANK`;
  - a `hex2seg` function.
- Sub-module `bin2bcd`:
  - ports `clk`, `reset`, `start`, `bin[10:0]`, `done`, `bcd[15:0]`;
  - FSM IDLE→SHIFT(11 cycles)→DONE→IDLE.

## Test plan
- **Reset and first digits** (SCAN_DIV=16): release reset → `an=FE`; after 16 cycles `an=FD`; after 128 cycles `an` is back to `FE`.
- **Hex mode:** `hex_in=32'h00A0_0F18` → digit 0 `seg=0000000` ('8'), digit 1 `1111001`, digit 2 `0001110`, digit 5 `0001000`.
- **Leading-zero blanking:**
  - With `LEADING_ZERO_BLANK_EN`: digits 6–7 read `7F`.
  - Without it: they read `1000000`.
- **Mode cycling:** five `mode_btn` pulses → `mode` sequence 1,2,3,4,0; the dp position follows `mode`.
- **Decimal conversion:** mode 4, `cnt_clk=11'd2047`:
  - after the second frame start, digits 3..0 read 2,0,4,7;
  - `cnt_clk=0` → only digit 0 shows '0' when blanking is enabled.
- **Reset mid-conversion:** assert `reset` 5 cycles after a `bin2bcd` start → all outputs return to reset values; the next conversion completes correctly.
